// File: rtl/error_source_arbiter.sv
// Error source arbiter: per-source holding registers, round-robin grant to the error FIFO, overrun statistics.
// Optional build macro ERR_ARB_SRC0_PRIORITY_EN gives source 0 fixed priority over the round-robin sources.
module error_source_arbiter #(
  parameter int NSRC = 5,
  parameter int DW   = 64,
  parameter int CW   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NSRC-1:0]    SRC_STB,
  input  logic [NSRC*DW-1:0] SRC_ECD,
  output logic               WVALID,
  input  logic               WREADY,
  output logic [DW-1:0]      WDATA,
  output logic [2:0]         WSRC,
  output logic [NSRC-1:0]    OVERRUN,
  output logic [CW-1:0]      DROP_CNT,
  input  logic               CLR_STAT
);

  logic [DW-1:0]   hold_p0 [NSRC];
  logic [NSRC-1:0] pend_p0;
  logic [2:0]      rr_ptr;

  logic            free;
  logic            gnt_any;
  logic [2:0]      gnt_idx;
  logic [NSRC-1:0] gnt_oh;
  logic [DW-1:0]   gnt_data;
  logic [NSRC-1:0] drop;
  logic [3:0]      drop_num;

  function automatic logic [3:0] drop_count(input logic [NSRC-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NSRC; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  function automatic logic [CW-1:0] cnt_sat(input logic [CW-1:0] cnt, input logic [3:0] n);
    logic [CW:0] sum;
    sum = {1'b0, cnt} + (CW+1)'(n);
    return sum[CW] ? '1 : sum[CW-1:0];
  endfunction

  assign free = ~WVALID | WREADY;

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (free) begin
`ifdef ERR_ARB_SRC0_PRIORITY_EN
      if (pend_p0[0]) gnt_any = 1'b1;
`endif
      for (int k = 0; k < NSRC; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NSRC) idx = idx - NSRC;
        if (!gnt_any && pend_p0[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = 3'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      gnt_oh[i] = gnt_any && (gnt_idx == 3'(i));
      if (gnt_oh[i]) gnt_data = hold_p0[i];
    end
  end

  // A strobe on a source being granted this cycle refills its slot instead of dropping
  assign drop     = SRC_STB & pend_p0 & ~gnt_oh;
  assign drop_num = drop_count(drop);

  // p0: per-source capture
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NSRC; i++)
      if (SRC_STB[i] && (!pend_p0[i] || gnt_oh[i])) hold_p0[i] <= SRC_ECD[i*DW +: DW];
  end

  // p1: grant into the output register and statistics
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_p0  <= '0;
      rr_ptr   <= '0;
      WVALID   <= 1'b0;
      WDATA    <= '0;
      WSRC     <= '0;
      OVERRUN  <= '0;
      DROP_CNT <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (SRC_STB[i] && (!pend_p0[i] || gnt_oh[i])) pend_p0[i] <= 1'b1;
        else if (gnt_oh[i])                           pend_p0[i] <= 1'b0;
      end
      if (free) WVALID <= gnt_any;
      if (gnt_any) begin
        WDATA <= gnt_data;
        WSRC  <= gnt_idx;
`ifdef ERR_ARB_SRC0_PRIORITY_EN
        if (gnt_idx != 3'd0)
`endif
        rr_ptr <= (gnt_idx == 3'(NSRC-1)) ? 3'd0 : gnt_idx + 3'd1;
      end
      if (CLR_STAT) begin
        OVERRUN  <= drop;
        DROP_CNT <= cnt_sat('0, drop_num);
      end else begin
        OVERRUN  <= OVERRUN | drop;
        DROP_CNT <= cnt_sat(DROP_CNT, drop_num);
      end
    end
  end

endmodule

// File: tb/tb_error_source_arbiter.sv
// Self-checking bench for error_source_arbiter: reference model compared every cycle plus directed literal checks.
module tb_error_source_arbiter;
  localparam int NSRC = 5;
  localparam int DW   = 64;
  localparam int CW   = 16;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic [NSRC-1:0]    stb = '0;
  logic [NSRC*DW-1:0] ecd = '0;
  logic               WREADY = 1'b0;
  logic               CLR_STAT = 1'b0;
  logic               WVALID;
  logic [DW-1:0]      WDATA;
  logic [2:0]         WSRC;
  logic [NSRC-1:0]    OVERRUN;
  logic [CW-1:0]      DROP_CNT;

  int errs = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  error_source_arbiter #(.NSRC(NSRC), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .SRC_STB(stb), .SRC_ECD(ecd),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSRC(WSRC),
    .OVERRUN(OVERRUN), .DROP_CNT(DROP_CNT), .CLR_STAT(CLR_STAT)
  );

  always #5 CLK = ~CLK;

  // reference model state
  bit [NSRC-1:0]   m_pend;
  logic [DW-1:0]   m_hold [NSRC];
  int              m_rr;
  bit              m_vld;
  logic [DW-1:0]   m_data;
  int              m_src;
  bit [NSRC-1:0]   m_ov;
  longint          m_cnt;
  int              g, nd;
  bit              m_free;
  logic [DW-1:0]   g_data;

  always @(posedge CLK) begin
    if (RESET) begin
      m_pend = '0; m_rr = 0; m_vld = 0; m_data = '0; m_src = 0; m_ov = '0; m_cnt = 0;
    end else begin
      m_free = !m_vld || WREADY;
      g = -1;
      g_data = '0;
      if (m_free) begin
`ifdef ERR_ARB_SRC0_PRIORITY_EN
        if (m_pend[0]) g = 0;
`endif
        for (int k = 0; k < NSRC; k++)
          if (g < 0 && m_pend[(m_rr + k) % NSRC]) g = (m_rr + k) % NSRC;
      end
      if (g >= 0) begin
        g_data = m_hold[g];
        m_pend[g] = 1'b0;
      end
      if (CLR_STAT) begin
        m_ov = '0;
        m_cnt = 0;
      end
      nd = 0;
      for (int i = 0; i < NSRC; i++) begin
        if (stb[i]) begin
          if (!m_pend[i]) begin
            m_hold[i] = ecd[i*DW +: DW];
            m_pend[i] = 1'b1;
          end else begin
            m_ov[i] = 1'b1;
            nd++;
          end
        end
      end
      m_cnt = m_cnt + nd;
      if (m_cnt > 65535) m_cnt = 65535;
      if (m_free) begin
        if (g >= 0) begin
          m_vld = 1'b1;
          m_data = g_data;
          m_src = g;
`ifdef ERR_ARB_SRC0_PRIORITY_EN
          if (g != 0)
`endif
          m_rr = (g + 1) % NSRC;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_wvalid", 64'(WVALID), 64'(m_vld));
      check("model_wdata", WDATA, m_data);
      check("model_wsrc", 64'(WSRC), 64'(m_src));
      check("model_overrun", 64'(OVERRUN), 64'(m_ov));
      check("model_drop_cnt", 64'(DROP_CNT), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; stb = '0; CLR_STAT = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  task automatic set_ecd(input int i, input logic [DW-1:0] v);
    ecd[i*DW +: DW] = v;
  endtask

  initial begin
    tick();
    do_reset();
    chk_en = 1'b1;
    check("rst_wvalid", 64'(WVALID), 64'd0);
    check("rst_wdata", WDATA, 64'd0);
    check("rst_wsrc", 64'(WSRC), 64'd0);
    check("rst_overrun", 64'(OVERRUN), 64'd0);
    check("rst_drop", 64'(DROP_CNT), 64'd0);

    // single report, two-cycle latency
    WREADY = 1'b1;
    stb = 5'b00100; set_ecd(2, 64'hA5);
    tick();
    stb = '0;
    check("lat_t1_wvalid", 64'(WVALID), 64'd0);
    tick();
    check("lat_t2_wvalid", 64'(WVALID), 64'd1);
    check("lat_t2_wdata", WDATA, 64'hA5);
    check("lat_t2_wsrc", 64'(WSRC), 64'd2);
    tick();
    check("lat_t3_wvalid", 64'(WVALID), 64'd0);
    check("lat_overrun", 64'(OVERRUN), 64'd0);
    check("lat_drop", 64'(DROP_CNT), 64'd0);

    // all sources at once
    do_reset();
    WREADY = 1'b1;
    stb = 5'b11111;
    for (int i = 0; i < NSRC; i++) set_ecd(i, 64'(i + 1));
    tick();
    stb = '0;
    for (int k = 0; k < NSRC; k++) begin
      tick();
      check("all_wvalid", 64'(WVALID), 64'd1);
      check("all_wsrc", 64'(WSRC), 64'(k));
      check("all_wdata", WDATA, 64'(k + 1));
    end
    tick();
    check("all_done", 64'(WVALID), 64'd0);

    // stall, refill behind the grant, then overrun
    do_reset();
    WREADY = 1'b0;
    stb = 5'b00010; set_ecd(1, 64'd1);
    tick();
    stb = '0;
    tick();
    check("stall_wvalid", 64'(WVALID), 64'd1);
    check("stall_wdata", WDATA, 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_hold_wdata", WDATA, 64'd1);
    end
    stb = 5'b00010; set_ecd(1, 64'd2);
    tick();
    check("refill_no_overrun", 64'(OVERRUN), 64'd0);
    set_ecd(1, 64'd3);
    tick();
    stb = '0;
    check("ovr_flag", 64'(OVERRUN), 64'b00010);
    check("ovr_drop", 64'(DROP_CNT), 64'd1);
    check("ovr_first_wdata", WDATA, 64'd1);
    WREADY = 1'b1;
    tick();
    check("ovr_second_wvalid", 64'(WVALID), 64'd1);
    check("ovr_second_wdata", WDATA, 64'd2);
    tick();
    check("ovr_after_wvalid", 64'(WVALID), 64'd0);

    // drop counter saturation and clear
    do_reset();
    WREADY = 1'b0;
    stb = 5'b01000; set_ecd(3, 64'h33);
    repeat (2 + 65539) tick();
    check("sat_drop", 64'(DROP_CNT), 64'hFFFF);
    check("sat_overrun", 64'(OVERRUN), 64'b01000);
    stb = '0; CLR_STAT = 1'b1;
    tick();
    CLR_STAT = 1'b0;
    check("clr_drop", 64'(DROP_CNT), 64'd0);
    check("clr_overrun", 64'(OVERRUN), 64'd0);
    stb = 5'b00010; set_ecd(1, 64'h11);
    tick();
    stb = 5'b01010; CLR_STAT = 1'b1;
    tick();
    stb = '0; CLR_STAT = 1'b0;
    check("clr_drop_wins_cnt", 64'(DROP_CNT), 64'd2);
    check("clr_drop_wins_flag", 64'(OVERRUN), 64'b01010);

    // fairness between two constantly strobing sources
    do_reset();
    WREADY = 1'b1;
    stb = 5'b10001; set_ecd(0, 64'hC0); set_ecd(4, 64'hC4);
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_wvalid", 64'(WVALID), 64'd1);
`ifdef ERR_ARB_SRC0_PRIORITY_EN
      check("rr_wsrc", 64'(WSRC), 64'd0);
`else
      check("rr_wsrc", 64'(WSRC), (k % 2 == 1) ? 64'd4 : 64'd0);
`endif
    end
    stb = '0;
    repeat (3) tick();

    // reset in the middle of a transfer
    do_reset();
    WREADY = 1'b0;
    stb = 5'b01111;
    for (int i = 0; i < NSRC; i++) set_ecd(i, 64'(16 + i));
    tick();
    stb = '0;
    tick();
    check("mid_wvalid", 64'(WVALID), 64'd1);
    check("mid_wsrc", 64'(WSRC), 64'd0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mid_rst_wvalid", 64'(WVALID), 64'd0);
    check("mid_rst_wdata", WDATA, 64'd0);
    check("mid_rst_wsrc", 64'(WSRC), 64'd0);
    WREADY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mid_no_stale", 64'(WVALID), 64'd0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
